hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and pipeline-sequencing controller for the 5-stage pipelined RISC-V core.
- Drives stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding selects.
- Sequences multi-cycle data-memory waits with a small FSM and a timeout.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before forced release; must be ≥1 and < 2^TO_W.
- TO_W, 8, width of the internal wait counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- Rs1D  in  5  rs1 of the instruction in ID.
- Rs2D  in  5  rs2 of the instruction in ID.
- Rs1E  in  5  rs1 of the instruction in EX.
- Rs2E  in  5  rs2 of the instruction in EX.
- RdE  in  5  rd of the instruction in EX.
- resultSrcE  in  2  result-source select in EX; 2'b01 marks a load.
- pcSrcE  in  1  taken branch or jump resolved in EX.
- regWriteM  in  1  register-write enable in MEM.
- RdM  in  5  rd in MEM.
- regWriteW  in  1  register-write enable in WB.
- RdW  in  5  rd in WB.
- memReqM  in  1  data-memory access active in MEM.
- memReadyM  in  1  data memory completes the access this cycle.
- stallF  out  1  hold PC.
- stallD  out  1  hold IF/ID.
- stallE  out  1  hold ID/EX.
- stallM  out  1  hold EX/MEM.
- flushD  out  1  clear IF/ID.
- flushE  out  1  clear ID/EX (its clr input).
- flushW  out  1  insert a bubble into MEM/WB.
- forwardAE  out  2  ALU operand A select.
- forwardBE  out  2  ALU operand B select.
- memErr  out  1  sticky flag: memory-wait timeout occurred.
- stallCount  out  CNT_W  cycles with stallF=1, saturating.
- flushCount  out  CNT_W  branch/jump flushes applied, saturating.

Behaviour:
- Forwarding (combinational, per operand, shown for A; B uses Rs2E):
  - 2'b10 if regWriteM && RdM!=0 && RdM==Rs1E;
  - else 2'b01 if regWriteW && RdW!=0 && RdW==Rs1E;
  - else 2'b00. MEM has priority over WB.
- lwStall = resultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- timeoutHit = state==MEM_WAIT && waitCnt==MEM_TIMEOUT.
- memStall = memReqM && !memReadyM && !timeoutHit.
- Normal operation (memStall=0):
  - stallF = stallD = lwStall;
  - flushD = pcSrcE;
  - flushE = lwStall | pcSrcE;
  - stallE = stallM = flushW = 0.
- During memStall=1:
  - stallF = stallD = stallE = stallM = 1;
  - flushW = 1;
  - flushD = flushE = 0. This suppresses load-use and branch flushes. pcSrcE persists because EX is held, so the flush applies on the first non-stalled cycle.
- FSM, two states, RUN and MEM_WAIT; waitCnt is TO_W bits:
  - RUN: if memStall → MEM_WAIT with waitCnt←1; else stay.
  - MEM_WAIT, memReadyM=1 → RUN with waitCnt←0.
  - MEM_WAIT, timeoutHit → RUN, memErr←1, waitCnt←0. The stall is released on the timeout cycle itself.
  - MEM_WAIT otherwise → stay, waitCnt←waitCnt+1.
  - memReqM dropping while in MEM_WAIT → RUN.
- Counters:
  - stallCount += 1 each cycle stallF=1;
  - flushCount += 1 each cycle pcSrcE && !memStall;
  - both saturate at all-ones and never wrap.
- Reset, while rst=1 and on the following edge:
  - state←RUN; waitCnt, memErr, stallCount, flushCount ← 0;
  - combinational outputs forced to stalls=0, flushD=flushE=flushW=1, forwardAE=forwardBE=0.
  - Reset mid-MEM_WAIT abandons the wait with no memErr.
- Latency: all controls are combinational from inputs plus current state; no added cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - constants RESULT_SRC_MEM=2'b01, FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state enum {RUN, MEM_WAIT}.
- One natural sub-module, forward_unit, instantiated once with both operands or twice with one operand each.
- FSM and counters stay in hazard_ctrl.

Test Plan:
- Rs1E=5, regWriteM=1 RdM=5, regWriteW=1 RdW=5 → forwardAE=10. Set RdM=0 → forwardAE=01.
- Load in EX (resultSrcE=01, RdE=7), Rs2D=7 → stallF=stallD=1, flushE=1 for one cycle, stallCount=1.
- pcSrcE=1, no memReq → flushD=flushE=1, flushCount increments by 1.
- memReqM=1, memReadyM=0 for 3 cycles then 1 → stalls and flushW high exactly 3 cycles, FSM returns to RUN. A concurrent pcSrcE flush appears only on the release cycle; flushCount+1 only.
- MEM_TIMEOUT=4, memReadyM stuck 0 → stalls release on cycle 5, memErr=1 and sticky.
- rst asserted mid-MEM_WAIT → next cycle state RUN, counters 0, memErr=0; with rst held, flushD=flushE=flushW=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings used by the hazard controller and its forwarding unit.
package pipe_pkg;

  // Result-source encoding that marks a load in EX.
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // ALU operand forwarding selects.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Memory-wait sequencer states.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Single-operand EX forwarding select; the MEM-stage producer wins over WB.
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] i_rs_e,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_rd_m,
  input  logic       i_reg_write_w,
  input  logic [4:0] i_rd_w,
  output logic [1:0] o_fwd
);

  // Pick the youngest in-flight producer of the source register; x0 is never forwarded.
  always_comb begin
    o_fwd = FWD_NONE;
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_MEM;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_WB;
    end else begin
      o_fwd = FWD_NONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls, branch
// flushes, EX forwarding, data-memory wait sequencing with timeout, debug counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       resultSrcE,
  input  logic             pcSrcE,
  input  logic             regWriteM,
  input  logic [4:0]       RdM,
  input  logic             regWriteW,
  input  logic [4:0]       RdW,
  input  logic             memReqM,
  input  logic             memReadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam logic [TO_W-1:0]  LP_TIMEOUT  = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0]  LP_WAIT_ONE = TO_W'(1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};

  hz_state_t        r_state;
  logic [TO_W-1:0]  r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_lw_stall;
  logic       w_timeout_hit;
  logic       w_mem_stall;

  forward_unit u_fwd_a (
    .i_rs_e        (Rs1E),
    .i_reg_write_m (regWriteM),
    .i_rd_m        (RdM),
    .i_reg_write_w (regWriteW),
    .i_rd_w        (RdW),
    .o_fwd         (w_fwd_a)
  );

  forward_unit u_fwd_b (
    .i_rs_e        (Rs2E),
    .i_reg_write_m (regWriteM),
    .i_rd_m        (RdM),
    .i_reg_write_w (regWriteW),
    .i_rd_w        (RdW),
    .o_fwd         (w_fwd_b)
  );

  assign w_lw_stall    = (resultSrcE == RESULT_SRC_MEM) && (RdE != 5'd0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_timeout_hit = (r_state == MEM_WAIT) && (r_wait_cnt == LP_TIMEOUT);
  // A timed-out access stops stalling on the timeout cycle itself.
  assign w_mem_stall   = memReqM && !memReadyM && !w_timeout_hit;

  // Pipeline stall/flush/forward controls; a memory stall freezes the whole front
  // and holds off EX flushes so a pending pcSrcE applies once the pipe moves again.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    forwardAE = FWD_NONE;
    forwardBE = FWD_NONE;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushW = 1'b1;
    end else if (w_mem_stall) begin
      stallF    = 1'b1;
      stallD    = 1'b1;
      stallE    = 1'b1;
      stallM    = 1'b1;
      flushW    = 1'b1;
      forwardAE = w_fwd_a;
      forwardBE = w_fwd_b;
    end else begin
      stallF    = w_lw_stall;
      stallD    = w_lw_stall;
      flushD    = pcSrcE;
      flushE    = w_lw_stall | pcSrcE;
      forwardAE = w_fwd_a;
      forwardBE = w_fwd_b;
    end
  end

  // Memory-wait sequencer: counts consecutive wait cycles and forces release on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= LP_WAIT_ONE;
          end else begin
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!memReqM || memReadyM) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (w_timeout_hit) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + LP_WAIT_ONE;
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating debug counters for stalled-fetch cycles and applied branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallF && (r_stall_cnt != LP_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
      end
      if (pcSrcE && !w_mem_stall && (r_flush_cnt != LP_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
      end
    end
  end

  assign memErr     = r_mem_err;
  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes the reference model's expected
// controls for each cycle, a negedge monitor pops and compares against the DUT.
module tb_hazard_ctrl;

  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rse;
    logic       pc, rwm;
    logic [4:0] rdm;
    logic       rww;
    logic [4:0] rdw;
    logic       mreq, mrdy;
  } in_t;

  typedef struct {
    logic sF, sD, sE, sM, fD, fE, fW;
    logic [1:0] fa, fb;
    logic err;
    int   sc, fc;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] resultSrcE;
  logic pcSrcE, regWriteM, regWriteW, memReqM, memReadyM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
  logic [1:0] forwardAE, forwardBE;
  logic [CNT_W-1:0] stallCount, flushCount;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .resultSrcE(resultSrcE), .pcSrcE(pcSrcE), .regWriteM(regWriteM),
    .RdM(RdM), .regWriteW(regWriteW), .RdW(RdW), .memReqM(memReqM),
    .memReadyM(memReadyM), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .memErr(memErr),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference state: how many consecutive memory-stall cycles precede this one,
  // the sticky error, and the two event totals.
  int  m_run  = 0;
  bit  m_err  = 1'b0;
  int  m_sc   = 0;
  int  m_fc   = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t x);
    if (x.rwm && x.rdm != 5'd0 && x.rdm == rs) return 2'b10;
    if (x.rww && x.rdw != 5'd0 && x.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic in_t idle();
    in_t x;
    x.rst = 1'b0; x.rs1d = 5'd0; x.rs2d = 5'd0; x.rs1e = 5'd0; x.rs2e = 5'd0;
    x.rde = 5'd0; x.rse = 2'b00; x.pc = 1'b0; x.rwm = 1'b0; x.rdm = 5'd0;
    x.rww = 1'b0; x.rdw = 5'd0; x.mreq = 1'b0; x.mrdy = 1'b0;
    return x;
  endfunction

  task automatic step(input in_t x);
    out_t e;
    bit lw, to, ms;
    @(posedge clk);
    #1;
    rst = x.rst; Rs1D = x.rs1d; Rs2D = x.rs2d; Rs1E = x.rs1e; Rs2E = x.rs2e;
    RdE = x.rde; resultSrcE = x.rse; pcSrcE = x.pc; regWriteM = x.rwm; RdM = x.rdm;
    regWriteW = x.rww; RdW = x.rdw; memReqM = x.mreq; memReadyM = x.mrdy;

    lw = (x.rse == 2'b01) && (x.rde != 5'd0) && (x.rde == x.rs1d || x.rde == x.rs2d);
    to = (m_run == TIMEOUT);
    ms = x.mreq && !x.mrdy && !to;
    e.err = m_err; e.sc = m_sc; e.fc = m_fc;
    if (x.rst) begin
      {e.sF, e.sD, e.sE, e.sM} = 4'b0000;
      {e.fD, e.fE, e.fW} = 3'b111;
      e.fa = 2'b00; e.fb = 2'b00;
    end else begin
      e.fa = ref_fwd(x.rs1e, x);
      e.fb = ref_fwd(x.rs2e, x);
      if (ms) begin
        {e.sF, e.sD, e.sE, e.sM, e.fW} = 5'b11111;
        {e.fD, e.fE} = 2'b00;
      end else begin
        e.sF = lw; e.sD = lw; e.sE = 1'b0; e.sM = 1'b0; e.fW = 1'b0;
        e.fD = x.pc; e.fE = lw | x.pc;
      end
    end
    exp_q.push_back(e);

    if (x.rst) begin
      m_run = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (e.sF && m_sc < CMAX) m_sc++;
      if (x.pc && !ms && m_fc < CMAX) m_fc++;
      if (x.mreq && !x.mrdy && to) m_err = 1'b1;
      m_run = ms ? m_run + 1 : 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  // Monitor: every negedge with an outstanding expectation compares all controls.
  always @(negedge clk) begin
    out_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stallF", {31'd0, stallF}, {31'd0, e.sF});
      chk("stallD", {31'd0, stallD}, {31'd0, e.sD});
      chk("stallE", {31'd0, stallE}, {31'd0, e.sE});
      chk("stallM", {31'd0, stallM}, {31'd0, e.sM});
      chk("flushD", {31'd0, flushD}, {31'd0, e.fD});
      chk("flushE", {31'd0, flushE}, {31'd0, e.fE});
      chk("flushW", {31'd0, flushW}, {31'd0, e.fW});
      chk("forwardAE", {30'd0, forwardAE}, {30'd0, e.fa});
      chk("forwardBE", {30'd0, forwardBE}, {30'd0, e.fb});
      chk("memErr", {31'd0, memErr}, {31'd0, e.err});
      chk("stallCount", {27'd0, stallCount}, e.sc);
      chk("flushCount", {27'd0, flushCount}, e.fc);
    end
  end

  initial begin
    in_t x;
    bit  hold_mode;
    int  drain;

    // Reset held two cycles.
    x = idle(); x.rst = 1'b1;
    step(x); step(x);

    // Forwarding: MEM beats WB, then WB once RdM is x0.
    x = idle(); x.rs1e = 5'd5; x.rwm = 1'b1; x.rdm = 5'd5; x.rww = 1'b1; x.rdw = 5'd5;
    step(x);
    x.rdm = 5'd0; step(x);

    // Load-use on rs2 for one cycle.
    x = idle(); x.rse = 2'b01; x.rde = 5'd7; x.rs2d = 5'd7; step(x);
    step(idle());

    // Taken branch with no memory access.
    x = idle(); x.pc = 1'b1; step(x);
    step(idle());

    // Three-cycle memory wait with a pending branch, released by memReadyM.
    x = idle(); x.mreq = 1'b1; x.pc = 1'b1;
    repeat (3) step(x);
    x.mrdy = 1'b1; step(x);
    step(idle());

    // Memory never ready: timeout releases the stall, memErr sticks.
    x = idle(); x.mreq = 1'b1;
    repeat (6) step(x);
    repeat (2) step(idle());

    // Reset in the middle of a wait clears everything.
    x = idle(); x.mreq = 1'b1;
    repeat (2) step(x);
    x.rst = 1'b1; step(x); step(x);
    repeat (2) step(idle());

    // Randomized traffic, alternating between responsive and stuck memory.
    hold_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) hold_mode = ~hold_mode;
      x.rst  = ($urandom_range(0, 149) == 0);
      x.rs1d = 5'($urandom_range(0, 3)); x.rs2d = 5'($urandom_range(0, 3));
      x.rs1e = 5'($urandom_range(0, 3)); x.rs2e = 5'($urandom_range(0, 3));
      x.rde  = 5'($urandom_range(0, 3)); x.rse = 2'($urandom_range(0, 3));
      x.pc   = ($urandom_range(0, 3) == 0);
      x.rwm  = 1'($urandom_range(0, 1)); x.rdm = 5'($urandom_range(0, 3));
      x.rww  = 1'($urandom_range(0, 1)); x.rdw = 5'($urandom_range(0, 3));
      x.mreq = ($urandom_range(0, 9) < 6);
      x.mrdy = hold_mode ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      step(x);
    end

    // Let the monitor drain, bounded.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
